// File: rtl/ahb_sram_slave_if.sv
// AHB5 bus bundle between a master/interconnect and the SRAM slave.
// hready is driven by the interconnect (the bus-level ready), so it sits on the master side.
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MASTER_ID_WIDTH = 4
);
    logic                       hsel;
    logic [ADDR_WIDTH-1:0]      haddr;
    logic [1:0]                 htrans;
    logic                       hwrite;
    logic [2:0]                 hsize;
    logic [2:0]                 hburst;
    logic [6:0]                 hprot;
    logic                       hnonsec;
    logic                       hexcl;
    logic [MASTER_ID_WIDTH-1:0] hmaster;
    logic                       hready;
    logic [DATA_WIDTH-1:0]      hwdata;
    logic [DATA_WIDTH-1:0]      hrdata;
    logic                       hreadyout;
    logic [1:0]                 hresp;
    logic                       hexokay;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hnonsec,
               hexcl, hmaster, hready, hwdata,
        input  hrdata, hreadyout, hresp, hexokay
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hnonsec,
               hexcl, hmaster, hready, hwdata,
        output hrdata, hreadyout, hresp, hexokay
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB5 SRAM slave with wait states, byte-lane writes, error responses and write->read forwarding.
// Define AHB_EXCL_MON_EN to build the per-master exclusive-access reservation monitor.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int WAIT_STATES     = 0,
    parameter int MASTER_ID_WIDTH = 4
) (
    input logic             hclk,
    input logic             hrst,
    ahb_sram_slave_if.slave bus
);
    localparam int         BYTES      = DATA_WIDTH / 8;
    localparam int         BYTE_BITS  = $clog2(BYTES);
    localparam int         IDX_BITS   = $clog2(DEPTH_WORDS);
    localparam int         WORD_BITS  = BYTE_BITS + IDX_BITS;
    localparam logic [3:0] WS         = 4'(WAIT_STATES);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_OKAY_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                     r_state;
    logic [3:0]                 r_waitCnt;
    logic [IDX_BITS-1:0]        r_idx;
    logic [BYTE_BITS-1:0]       r_off;
    logic                       r_write;
    logic [2:0]                 r_size;
    logic                       r_excl;
    logic [MASTER_ID_WIDTH-1:0] r_master;
    logic                       r_readyOut;
    logic [1:0]                 r_resp;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic                       r_exOkay;
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH_WORDS];

    logic                       w_canAccept;
    logic                       w_accept;
    logic                       w_oob;
    logic                       w_tooBig;
    logic [BYTE_BITS-1:0]       w_sizeMask;
    logic                       w_misaligned;
    logic                       w_err;
    logic                       w_inWait;
    logic [IDX_BITS-1:0]        w_srcIdx;
    logic                       w_srcWrite;
    logic                       w_srcExcl;
    logic [MASTER_ID_WIDTH-1:0] w_srcMaster;
    logic                       w_enterOkay;
    logic                       w_wrEn;
    logic                       w_exOkNext;
    logic [BYTES-1:0]           w_strb;
    logic [DATA_WIDTH-1:0]      w_wrWord;
    logic [DATA_WIDTH-1:0]      w_rdWord;
    logic                       w_unused;

    assign w_canAccept = (r_state == S_IDLE) || (r_state == S_OKAY_LAST) || (r_state == S_ERR2);
    assign w_accept    = w_canAccept && bus.hsel && bus.hready && bus.htrans[1];

    // Out of range, wider than the bus, or not aligned to its own size.
    assign w_oob        = (bus.haddr >> WORD_BITS) != '0;
    assign w_tooBig     = bus.hsize > 3'(BYTE_BITS);
    assign w_sizeMask   = BYTE_BITS'((32'd1 << bus.hsize) - 32'd1);
    assign w_misaligned = |(bus.haddr[BYTE_BITS-1:0] & w_sizeMask);
    assign w_err        = w_oob || w_tooBig || w_misaligned;

    assign w_inWait    = (r_state == S_WAIT);
    assign w_srcIdx    = w_inWait ? r_idx    : bus.haddr[BYTE_BITS +: IDX_BITS];
    assign w_srcWrite  = w_inWait ? r_write  : bus.hwrite;
    assign w_srcExcl   = w_inWait ? r_excl   : bus.hexcl;
    assign w_srcMaster = w_inWait ? r_master : bus.hmaster;
    assign w_enterOkay = (w_inWait && (r_waitCnt == 4'd0)) ||
                         (w_accept && !w_err && (WAIT_STATES == 0));

    // Aligned transfers: a lane belongs to the transfer when it falls in the same size-block as the offset.
    always_comb begin
        w_strb = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_strb[b] = (BYTE_BITS'(b) >> r_size) == (r_off >> r_size);
        end
    end

    always_comb begin
        w_wrWord = r_mem[r_idx];
        for (int b = 0; b < BYTES; b++) begin
            if (w_strb[b]) begin
                w_wrWord[8*b +: 8] = bus.hwdata[8*b +: 8];
            end
        end
        w_rdWord = (w_wrEn && (r_idx == w_srcIdx)) ? w_wrWord : r_mem[w_srcIdx];
    end

`ifdef AHB_EXCL_MON_EN
    localparam int NUM_MASTERS = 2 ** MASTER_ID_WIDTH;

    logic [NUM_MASTERS-1:0] r_resValid;
    logic [IDX_BITS-1:0]    r_resIdx [NUM_MASTERS];
    logic                   w_resHit;

    // A write committing this very cycle to the reserved word kills the reservation before it is checked.
    assign w_resHit   = r_resValid[w_srcMaster] && (r_resIdx[w_srcMaster] == w_srcIdx) &&
                        !(w_wrEn && (r_idx == w_srcIdx));
    assign w_exOkNext = w_srcExcl && (!w_srcWrite || w_resHit);
    assign w_wrEn     = (r_state == S_OKAY_LAST) && r_write && (!r_excl || r_exOkay);
    assign w_unused   = ^{bus.hburst, bus.hprot, bus.hnonsec, bus.htrans[0]};

    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            r_resValid <= '0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                r_resIdx[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (w_wrEn && (r_resIdx[m] == r_idx)) begin
                    r_resValid[m] <= 1'b0;
                end
            end
            if (w_enterOkay && w_srcExcl && !w_srcWrite) begin
                r_resValid[w_srcMaster] <= 1'b1;
                r_resIdx[w_srcMaster]   <= w_srcIdx;
            end
        end
    end
`else
    assign w_exOkNext = 1'b0;
    assign w_wrEn     = (r_state == S_OKAY_LAST) && r_write;
    assign w_unused   = ^{bus.hburst, bus.hprot, bus.hnonsec, bus.htrans[0], w_srcExcl, w_srcMaster};
`endif

    always_ff @(posedge hclk) begin
        if (w_wrEn) begin
            r_mem[r_idx] <= w_wrWord;
        end
    end

    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            r_state    <= S_IDLE;
            r_waitCnt  <= 4'd0;
            r_idx      <= '0;
            r_off      <= '0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
            r_excl     <= 1'b0;
            r_master   <= '0;
            r_readyOut <= 1'b1;
            r_resp     <= RESP_OKAY;
            r_rdata    <= '0;
            r_exOkay   <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        r_state    <= S_OKAY_LAST;
                        r_readyOut <= 1'b1;
                        r_exOkay   <= w_exOkNext;
                        if (!w_srcWrite) begin
                            r_rdata <= w_rdWord;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state    <= S_ERR2;
                    r_readyOut <= 1'b1;
                end
                default: begin
                    r_resp     <= RESP_OKAY;
                    r_exOkay   <= 1'b0;
                    r_readyOut <= 1'b1;
                    if (w_accept) begin
                        r_idx    <= bus.haddr[BYTE_BITS +: IDX_BITS];
                        r_off    <= bus.haddr[BYTE_BITS-1:0];
                        r_write  <= bus.hwrite;
                        r_size   <= bus.hsize;
                        r_excl   <= bus.hexcl;
                        r_master <= bus.hmaster;
                        if (w_err) begin
                            r_state    <= S_ERR1;
                            r_readyOut <= 1'b0;
                            r_resp     <= RESP_ERROR;
                            r_rdata    <= '0;
                        end else if (WAIT_STATES == 0) begin
                            r_state  <= S_OKAY_LAST;
                            r_exOkay <= w_exOkNext;
                            if (!w_srcWrite) begin
                                r_rdata <= w_rdWord;
                            end
                        end else begin
                            r_state    <= S_WAIT;
                            r_waitCnt  <= WS - 4'd1;
                            r_readyOut <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.hrdata    = r_rdata;
    assign bus.hreadyout = r_readyOut;
    assign bus.hresp     = r_resp;
    assign bus.hexokay   = r_exOkay;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance driven by a pipelined AHB master.
// Expected responses travel through a scoreboard queue from address phase to data-phase completion.
module tb_ahb_sram_slave;
`ifdef AHB_EXCL_MON_EN
    localparam bit EXCL_ON = 1'b1;
`else
    localparam bit EXCL_ON = 1'b0;
`endif

    typedef struct {
        int          id;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        bit          excl;
        logic [3:0]  master;
        logic [31:0] wdata;
        bit          checkData;
        logic [31:0] expData;
        logic [1:0]  expResp;
        bit          expExOkay;
        int          expWaits;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hrst = 1'b0;
    int          target = 0;
    logic        tbSel = 1'b0;
    logic [1:0]  tbTrans = 2'b00;
    logic [31:0] tbAddr = '0;
    logic        tbWrite = 1'b0;
    logic [2:0]  tbSize = 3'd0;
    logic        tbExcl = 1'b0;
    logic [3:0]  tbMaster = 4'd0;
    logic [31:0] tbWdata = '0;

    int   vecCount = 0;
    int   missCount = 0;
    vec_t vecs0[$];
    vec_t vecs3[$];
    vec_t expQ[$];
    vec_t pending;
    bit   havePending = 1'b0;
    vec_t v;
    vec_t idleVec;

    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASTER_ID_WIDTH(4)) if0 ();
    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASTER_ID_WIDTH(4)) if3 ();

    assign if0.hsel    = tbSel && (target == 0);
    assign if3.hsel    = tbSel && (target == 1);
    assign if0.haddr   = tbAddr;
    assign if3.haddr   = tbAddr;
    assign if0.htrans  = tbTrans;
    assign if3.htrans  = tbTrans;
    assign if0.hwrite  = tbWrite;
    assign if3.hwrite  = tbWrite;
    assign if0.hsize   = tbSize;
    assign if3.hsize   = tbSize;
    assign if0.hburst  = 3'b000;
    assign if3.hburst  = 3'b000;
    assign if0.hprot   = 7'b0000011;
    assign if3.hprot   = 7'b0000011;
    assign if0.hnonsec = 1'b0;
    assign if3.hnonsec = 1'b0;
    assign if0.hexcl   = tbExcl;
    assign if3.hexcl   = tbExcl;
    assign if0.hmaster = tbMaster;
    assign if3.hmaster = tbMaster;
    assign if0.hwdata  = tbWdata;
    assign if3.hwdata  = tbWdata;
    assign if0.hready  = if0.hreadyout;
    assign if3.hready  = if3.hreadyout;

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
                     .WAIT_STATES(0), .MASTER_ID_WIDTH(4)) dut0 (
        .hclk(hclk), .hrst(hrst), .bus(if0)
    );
    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
                     .WAIT_STATES(3), .MASTER_ID_WIDTH(4)) dut3 (
        .hclk(hclk), .hrst(hrst), .bus(if3)
    );

    logic        selReady;
    logic [1:0]  selResp;
    logic [31:0] selRdata;
    logic        selExOkay;
    assign selReady  = (target == 0) ? if0.hreadyout : if3.hreadyout;
    assign selResp   = (target == 0) ? if0.hresp     : if3.hresp;
    assign selRdata  = (target == 0) ? if0.hrdata    : if3.hrdata;
    assign selExOkay = (target == 0) ? if0.hexokay   : if3.hexokay;

    always #5 hclk = ~hclk;

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                input bit excl, input logic [3:0] m, input logic [31:0] wdata,
                                input bit chk, input logic [31:0] expData, input logic [1:0] resp,
                                input bit exOk, input int waits);
        vec_t r;
        r.id = 0; r.write = wr; r.addr = addr; r.size = size; r.excl = excl; r.master = m;
        r.wdata = wdata; r.checkData = chk; r.expData = expData; r.expResp = resp;
        r.expExOkay = exOk; r.expWaits = waits;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drives v's address phase and the pending data phase,
    // then waits for that data phase to complete and scores it.
    task automatic applyStimulus(input vec_t sv, input bit valid);
        int   lowCycles;
        bit   done;
        vec_t e;
        tbSel    = valid;
        tbTrans  = valid ? 2'b10 : 2'b00;
        tbAddr   = sv.addr;
        tbWrite  = sv.write;
        tbSize   = sv.size;
        tbExcl   = sv.excl;
        tbMaster = sv.master;
        tbWdata  = (havePending && pending.write) ? pending.wdata : 32'h0;
        if (valid) expQ.push_back(sv);
        if (havePending) e = expQ[0];
        lowCycles = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge hclk);
            if (havePending)
                checkOutput($sformatf("v%0d.hresp", e.id), {30'b0, selResp}, {30'b0, e.expResp});
            if (selReady) begin
                done = 1'b1;
            end else begin
                lowCycles++;
                if (lowCycles > 40) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL v%0d.timeout: got hreadyout low for %0d cycles, expected at most 40",
                             e.id, lowCycles);
                    done = 1'b1;
                end
            end
        end
        if (havePending) begin
            e = expQ.pop_front();
            checkOutput($sformatf("v%0d.waits", e.id), 32'(lowCycles), 32'(e.expWaits));
            checkOutput($sformatf("v%0d.hexokay", e.id), {31'b0, selExOkay}, {31'b0, e.expExOkay});
            if (e.checkData)
                checkOutput($sformatf("v%0d.hrdata", e.id), selRdata, e.expData);
        end
        pending = sv;
        havePending = valid;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idleVec = mk(0, 32'h0, 3'd0, 0, 4'd0, 32'h0, 0, 32'h0, 2'b00, 0, 0);

        // Zero-wait instance.
        vecs0.push_back(mk(1, 32'h10,   3'd2, 0, 4'd0, 32'hDEADBEEF, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h10,   3'd2, 0, 4'd0, 32'h0,        1, 32'hDEADBEEF, 2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h40,   3'd2, 0, 4'd0, 32'h11223344, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h41,   3'd0, 0, 4'd0, 32'h5555AA55, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h40,   3'd2, 0, 4'd0, 32'h0,        1, 32'h1122AA44, 2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h42,   3'd1, 0, 4'd0, 32'hBEEF7777, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h42,   3'd1, 0, 4'd0, 32'h0,        1, 32'hBEEFAA44, 2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h1000, 3'd2, 0, 4'd0, 32'h0,        1, 32'h0,        2'b01, 0, 1));
        vecs0.push_back(mk(0, 32'h03,   3'd1, 0, 4'd0, 32'h0,        1, 32'h0,        2'b01, 0, 1));
        vecs0.push_back(mk(1, 32'h41,   3'd1, 0, 4'd0, 32'hFFFFFFFF, 0, 32'h0,        2'b01, 0, 1));
        vecs0.push_back(mk(1, 32'h40,   3'd3, 0, 4'd0, 32'hFFFFFFFF, 0, 32'h0,        2'b01, 0, 1));
        vecs0.push_back(mk(0, 32'h40,   3'd2, 0, 4'd0, 32'h0,        1, 32'hBEEFAA44, 2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h13,   3'd0, 0, 4'd0, 32'h7F000000, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h10,   3'd2, 0, 4'd0, 32'h0,        1, 32'h7FADBEEF, 2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h50,   3'd2, 0, 4'd0, 32'h01010101, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h50,   3'd2, 1, 4'd1, 32'h0,        1, 32'h01010101, 2'b00, EXCL_ON, 0));
        vecs0.push_back(mk(1, 32'h50,   3'd2, 0, 4'd2, 32'h22222222, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h50,   3'd2, 1, 4'd1, 32'h11111111, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h50,   3'd2, 0, 4'd0, 32'h0,        1,
                           EXCL_ON ? 32'h22222222 : 32'h11111111, 2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h60,   3'd2, 0, 4'd3, 32'h00000000, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h60,   3'd2, 1, 4'd3, 32'h0,        1, 32'h00000000, 2'b00, EXCL_ON, 0));
        vecs0.push_back(mk(1, 32'h60,   3'd2, 1, 4'd3, 32'h00000033, 0, 32'h0,        2'b00, EXCL_ON, 0));
        vecs0.push_back(mk(0, 32'h60,   3'd2, 0, 4'd3, 32'h0,        1, 32'h00000033, 2'b00, 0, 0));
        vecs0.push_back(mk(1, 32'h60,   3'd2, 1, 4'd3, 32'h00000044, 0, 32'h0,        2'b00, 0, 0));
        vecs0.push_back(mk(0, 32'h60,   3'd2, 0, 4'd3, 32'h0,        1,
                           EXCL_ON ? 32'h00000033 : 32'h00000044, 2'b00, 0, 0));

        // Three-wait instance.
        vecs3.push_back(mk(1, 32'h20, 3'd2, 0, 4'd0, 32'hCAFEF00D, 0, 32'h0,        2'b00, 0, 3));
        vecs3.push_back(mk(0, 32'h20, 3'd2, 0, 4'd0, 32'h0,        1, 32'hCAFEF00D, 2'b00, 0, 3));
        vecs3.push_back(mk(0, 32'h01, 3'd1, 0, 4'd0, 32'h0,        1, 32'h0,        2'b01, 0, 1));
        vecs3.push_back(mk(1, 32'h30, 3'd2, 0, 4'd0, 32'h12345678, 0, 32'h0,        2'b00, 0, 3));
        vecs3.push_back(mk(0, 32'h20, 3'd2, 0, 4'd0, 32'h0,        1, 32'hCAFEF00D, 2'b00, 0, 3));

        #12;
        checkOutput("rst.hreadyout0", {31'b0, if0.hreadyout}, 32'd1);
        checkOutput("rst.hresp0",     {30'b0, if0.hresp},     32'd0);
        checkOutput("rst.hrdata0",    if0.hrdata,             32'd0);
        checkOutput("rst.hexokay0",   {31'b0, if0.hexokay},   32'd0);
        checkOutput("rst.hreadyout3", {31'b0, if3.hreadyout}, 32'd1);
        @(negedge hclk);
        hrst = 1'b1;
        @(posedge hclk);
        #1;

        target = 0;
        for (int i = 0; i < vecs0.size(); i++) begin
            v = vecs0[i];
            v.id = i;
            applyStimulus(v, 1'b1);
        end
        applyStimulus(idleVec, 1'b0);

        target = 1;
        for (int i = 0; i < vecs3.size(); i++) begin
            v = vecs3[i];
            v.id = 100 + i;
            applyStimulus(v, 1'b1);
        end
        applyStimulus(idleVec, 1'b0);

        // Reset pulsed while a write to 0x30 sits in its wait states.
        tbAddr = 32'h30; tbWrite = 1'b1; tbSize = 3'd2; tbExcl = 1'b0; tbMaster = 4'd0;
        tbSel = 1'b1; tbTrans = 2'b10;
        @(posedge hclk);
        #1;
        tbSel = 1'b0; tbTrans = 2'b00; tbWdata = 32'h99999999;
        @(negedge hclk);
        checkOutput("rstWait.inWait", {31'b0, if3.hreadyout}, 32'd0);
        #2 hrst = 1'b0;
        #1;
        checkOutput("rstWait.hreadyout", {31'b0, if3.hreadyout}, 32'd1);
        checkOutput("rstWait.hresp",     {30'b0, if3.hresp},     32'd0);
        checkOutput("rstWait.hrdata",    if3.hrdata,             32'd0);
        checkOutput("rstWait.hexokay",   {31'b0, if3.hexokay},   32'd0);
        @(negedge hclk);
        @(negedge hclk);
        hrst = 1'b1;
        @(posedge hclk);
        #1;
        v = mk(0, 32'h30, 3'd2, 0, 4'd0, 32'h0, 1, 32'h12345678, 2'b00, 0, 3);
        v.id = 200;
        applyStimulus(v, 1'b1);
        applyStimulus(idleVec, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
